// File: rtl/nand_op_scheduler.sv
// Multi-page command sequencer in front of the NAND page state machine: issues one
// erase/write/read enable per row, waits for the matching end, advances the row, reports done/error.
module nand_op_scheduler #(
  parameter int unsigned PAGE_BITS  = 6,
  parameter int unsigned BLOCK_BITS = 12,
  parameter int unsigned CNT_BITS   = 16,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1048576
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [PAGE_BITS+BLOCK_BITS-1:0] cmd_row,
  input  logic [CNT_BITS-1:0]             cmd_page_cnt,
  output logic                            en_erase_page,
  output logic                            en_write_page,
  output logic                            en_read,
  output logic [PAGE_BITS+BLOCK_BITS-1:0] row_addr,
  input  logic                            end_erase_page,
  input  logic                            end_write_page,
  input  logic                            end_read,
  input  logic                            nandflash_busy_Noresponse,
  output logic [CNT_BITS-1:0]             pages_done,
  output logic                            op_done,
  output logic [1:0]                      op_err
);

  localparam int unsigned RowBits = PAGE_BITS + BLOCK_BITS;
  localparam int unsigned TmoBits = $clog2(TIMEOUT + 1);
  localparam int unsigned GapBits = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] OpErase = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] OpRead  = 2'd3;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitEnd, StRelease, StFinish} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [RowBits-1:0]   row_q, row_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [CNT_BITS-1:0]  pdone_q, pdone_d;
  logic [1:0]           err_q, err_d;
  logic [TmoBits-1:0]   tmo_q, tmo_d;
  logic [GapBits-1:0]   gap_q, gap_d;
  logic [2:0]           en_q, en_d;
  logic                 op_done_q;
  logic [1:0]           op_err_q;
  logic                 end_sel;
  logic [BLOCK_BITS-1:0] blk_inc;

  assign blk_inc = row_q[RowBits-1:PAGE_BITS] + BLOCK_BITS'(1);

  always_comb begin
    end_sel = 1'b0;
    unique case (op_q)
      OpErase: end_sel = end_erase_page;
      OpWrite: end_sel = end_write_page;
      OpRead:  end_sel = end_read;
      default: end_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    pdone_d = pdone_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          row_d   = cmd_row;
          cnt_d   = cmd_page_cnt;
          pdone_d = '0;
          err_d   = 2'd0;
          if (cmd_op == 2'd0 || cmd_page_cnt == '0) begin
            err_d   = 2'd1;
            state_d = StFinish;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitEnd;
      end
      StWaitEnd: begin
        tmo_d = tmo_q + TmoBits'(1);
        gap_d = '0;
        // A completed operation takes priority over any error raised in the same cycle.
        if (end_sel) begin
          pdone_d = pdone_q + CNT_BITS'(1);
          state_d = StRelease;
        end else if (nandflash_busy_Noresponse) begin
          err_d   = 2'd3;
          state_d = StRelease;
        end else if (tmo_q == TmoBits'(TIMEOUT - 1)) begin
          err_d   = 2'd2;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Gap is counted only over cycles where end_* is already low.
        if (end_sel) begin
          gap_d = '0;
        end else if (gap_q != GapBits'(GAP_CYCLES)) begin
          gap_d = gap_q + GapBits'(1);
        end
        if (!end_sel && gap_q >= GapBits'(GAP_CYCLES - 1)) begin
          if (err_q != 2'd0 || pdone_q == cnt_q) begin
            state_d = StFinish;
          end else begin
            state_d = StIssue;
            row_d   = (op_q == OpErase) ? {blk_inc, {PAGE_BITS{1'b0}}} : row_q + RowBits'(1);
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    en_d = 3'b000;
    if (state_d == StWaitEnd) begin
      unique case (op_d)
        OpErase: en_d = 3'b001;
        OpWrite: en_d = 3'b010;
        OpRead:  en_d = 3'b100;
        default: en_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= 2'd0;
      row_q     <= '0;
      cnt_q     <= '0;
      pdone_q   <= '0;
      err_q     <= 2'd0;
      tmo_q     <= '0;
      gap_q     <= '0;
      en_q      <= 3'b000;
      op_done_q <= 1'b0;
      op_err_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      pdone_q   <= pdone_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      en_q      <= en_d;
      op_done_q <= (state_q == StFinish);
      op_err_q  <= (state_q == StFinish) ? err_q : 2'd0;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign en_erase_page = en_q[0];
  assign en_write_page = en_q[1];
  assign en_read       = en_q[2];
  assign row_addr      = row_q;
  assign pages_done    = pdone_q;
  assign op_done       = op_done_q;
  assign op_err        = op_err_q;

endmodule

// File: tb/tb_nand_op_scheduler.sv
// Directed bench for nand_op_scheduler: each task drives one scenario and checks inline.
module tb_nand_op_scheduler;

  localparam int unsigned PB  = 6;
  localparam int unsigned BB  = 12;
  localparam int unsigned CB  = 16;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 40;
  localparam int unsigned RB  = PB + BB;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [RB-1:0] cmd_row;
  logic [CB-1:0] cmd_page_cnt;
  logic          en_erase_page, en_write_page, en_read;
  logic [RB-1:0] row_addr;
  logic          end_erase_page, end_write_page, end_read;
  logic          nandflash_busy_Noresponse;
  logic [CB-1:0] pages_done;
  logic          op_done;
  logic [1:0]    op_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nand_op_scheduler #(
    .PAGE_BITS (PB),
    .BLOCK_BITS(BB),
    .CNT_BITS  (CB),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_op                   (cmd_op),
    .cmd_row                  (cmd_row),
    .cmd_page_cnt             (cmd_page_cnt),
    .en_erase_page            (en_erase_page),
    .en_write_page            (en_write_page),
    .en_read                  (en_read),
    .row_addr                 (row_addr),
    .end_erase_page           (end_erase_page),
    .end_write_page           (end_write_page),
    .end_read                 (end_read),
    .nandflash_busy_Noresponse(nandflash_busy_Noresponse),
    .pages_done               (pages_done),
    .op_done                  (op_done),
    .op_err                   (op_err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge with cmd_ready high; returns one negedge later with cmd_valid low.
  task automatic issue_cmd(input logic [1:0] op, input logic [RB-1:0] row,
                           input logic [CB-1:0] cnt);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_row      = row;
    cmd_page_cnt = cnt;
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_en(input int which, input int budget, output bit ok);
    logic [2:0] ens;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      ens = {en_read, en_write_page, en_erase_page};
      if (ens[which]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok, output logic [1:0] err);
    ok  = 1'b0;
    err = 2'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (op_done) begin
        ok  = 1'b1;
        err = op_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    vectors++;
    if ({cmd_ready, en_erase_page, en_write_page, en_read, op_done} !== 5'b10000) begin
      $display("FAIL reset_ctrl: got %b, want 10000",
               {cmd_ready, en_erase_page, en_write_page, en_read, op_done});
      miscompares++;
    end
    vectors++;
    if (row_addr !== '0 || pages_done !== '0 || op_err !== 2'd0) begin
      $display("FAIL reset_data: row %0h pages %0d err %0d, want 0 0 0",
               row_addr, pages_done, op_err);
      miscompares++;
    end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_write();
    logic [RB-1:0] exp_row [3];
    bit ok;
    logic [1:0] err;
    int extra;
    exp_row[0] = {12'd5, 6'd62};
    exp_row[1] = {12'd5, 6'd63};
    exp_row[2] = {12'd6, 6'd0};
    issue_cmd(2'd2, exp_row[0], 16'd3);
    vectors++;
    if (cmd_ready !== 1'b0 || en_write_page !== 1'b0) begin
      $display("FAIL write_accept: ready %b en %b, want 0 0", cmd_ready, en_write_page);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (en_write_page !== 1'b1) begin
      $display("FAIL write_latency: en_write_page %b, want 1", en_write_page);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      wait_en(1, 20, ok);
      vectors++;
      if (!ok) begin
        $display("FAIL write_en[%0d]: en_write_page %b, want 1", i, en_write_page);
        miscompares++;
      end
      vectors++;
      if (row_addr !== exp_row[i] || {en_erase_page, en_read} !== 2'b00) begin
        $display("FAIL write_row[%0d]: row %0h others %b, want %0h 00", i, row_addr,
                 {en_erase_page, en_read}, exp_row[i]);
        miscompares++;
      end
      tick(3);
      end_write_page = 1'b1;
      @(negedge clk);
      vectors++;
      if (en_write_page !== 1'b0) begin
        $display("FAIL write_drop[%0d]: en_write_page %b, want 0", i, en_write_page);
        miscompares++;
      end
      end_write_page = 1'b0;
    end
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd0 || pages_done !== 16'd3) begin
      $display("FAIL write_done: done %b err %0d pages %0d, want 1 0 3", ok, err, pages_done);
      miscompares++;
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (op_done) extra++;
    end
    vectors++;
    if (extra !== 0 || cmd_ready !== 1'b1) begin
      $display("FAIL write_once: extra dones %0d ready %b, want 0 1", extra, cmd_ready);
      miscompares++;
    end
  endtask

  task automatic test_erase();
    logic [RB-1:0] exp_row [2];
    bit ok;
    logic [1:0] err;
    exp_row[0] = {12'd7, 6'd9};
    exp_row[1] = {12'd8, 6'd0};
    issue_cmd(2'd1, exp_row[0], 16'd2);
    for (int i = 0; i < 2; i++) begin
      wait_en(0, 20, ok);
      if (i == 0) begin
        // a second command while busy must be dropped
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
      end
      vectors++;
      if (!ok || row_addr !== exp_row[i] || {en_write_page, en_read} !== 2'b00) begin
        $display("FAIL erase_row[%0d]: en %b row %0h others %b, want 1 %0h 00", i, ok, row_addr,
                 {en_write_page, en_read}, exp_row[i]);
        miscompares++;
      end
      tick(2);
      end_erase_page = 1'b1;
      @(negedge clk);
      end_erase_page = 1'b0;
    end
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd0 || pages_done !== 16'd2) begin
      $display("FAIL erase_done: done %b err %0d pages %0d, want 1 0 2", ok, err, pages_done);
      miscompares++;
    end
    tick(1);
  endtask

  task automatic test_read_hold();
    bit ok, leaked;
    logic [1:0] err;
    int n;
    issue_cmd(2'd3, {12'd1, 6'd0}, 16'd2);
    wait_en(2, 20, ok);
    end_read = 1'b1;
    @(negedge clk);
    leaked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en_read || op_done) leaked = 1'b1;
    end
    vectors++;
    if (!ok || leaked) begin
      $display("FAIL read_hold: first en %b reissue-during-hold %b, want 1 0", ok, leaked);
      miscompares++;
    end
    end_read = 1'b0;
    n = 0;
    while (!en_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n < GAP || n > GAP + 2) begin
      $display("FAIL read_gap: %0d cycles end_read low before reissue, want %0d..%0d",
               n, GAP, GAP + 2);
      miscompares++;
    end
    vectors++;
    if (row_addr !== {12'd1, 6'd1}) begin
      $display("FAIL read_row2: row %0h, want %0h", row_addr, {12'd1, 6'd1});
      miscompares++;
    end
    end_read = 1'b1;
    @(negedge clk);
    end_read = 1'b0;
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd0 || pages_done !== 16'd2) begin
      $display("FAIL read_done: done %b err %0d pages %0d, want 1 0 2", ok, err, pages_done);
      miscompares++;
    end
    tick(1);
  endtask

  task automatic test_timeout();
    bit ok;
    logic [1:0] err;
    int n;
    issue_cmd(2'd2, {12'd3, 6'd3}, 16'd2);
    wait_en(1, 20, ok);
    n = 0;
    while (en_write_page && n < int'(TMO) + 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!ok || en_write_page !== 1'b0 || n < int'(TMO) - 1 || n > int'(TMO) + 1) begin
      $display("FAIL timeout_drop: en held %0d cycles (en now %b), want %0d", n,
               en_write_page, TMO);
      miscompares++;
    end
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd2 || pages_done !== 16'd0) begin
      $display("FAIL timeout_done: done %b err %0d pages %0d, want 1 2 0", ok, err, pages_done);
      miscompares++;
    end
    tick(1);
  endtask

  task automatic test_busy();
    bit ok;
    logic [1:0] err;
    issue_cmd(2'd3, {12'd2, 6'd3}, 16'd1);
    wait_en(2, 20, ok);
    tick(1);
    nandflash_busy_Noresponse = 1'b1;
    @(negedge clk);
    nandflash_busy_Noresponse = 1'b0;
    vectors++;
    if (!ok || en_read !== 1'b0) begin
      $display("FAIL busy_drop: en seen %b en_read %b, want 1 0", ok, en_read);
      miscompares++;
    end
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd3 || pages_done !== 16'd0) begin
      $display("FAIL busy_done: done %b err %0d pages %0d, want 1 3 0", ok, err, pages_done);
      miscompares++;
    end
    tick(1);
    issue_cmd(2'd3, {12'd2, 6'd3}, 16'd1);
    wait_en(2, 20, ok);
    nandflash_busy_Noresponse = 1'b1;
    end_read = 1'b1;
    @(negedge clk);
    nandflash_busy_Noresponse = 1'b0;
    end_read = 1'b0;
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd0 || pages_done !== 16'd1) begin
      $display("FAIL busy_end_tie: done %b err %0d pages %0d, want 1 0 1", ok, err, pages_done);
      miscompares++;
    end
    tick(1);
  endtask

  task automatic test_illegal();
    logic [1:0] ops [2];
    logic [CB-1:0] cnts [2];
    ops[0] = 2'd0; cnts[0] = 16'd5;
    ops[1] = 2'd3; cnts[1] = 16'd0;
    for (int i = 0; i < 2; i++) begin
      issue_cmd(ops[i], {12'd9, 6'd9}, cnts[i]);
      vectors++;
      if (op_done !== 1'b0 || cmd_ready !== 1'b0) begin
        $display("FAIL illegal_early[%0d]: done %b ready %b, want 0 0", i, op_done, cmd_ready);
        miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (op_done !== 1'b1 || op_err !== 2'd1 ||
          {en_erase_page, en_write_page, en_read} !== 3'b000) begin
        $display("FAIL illegal_done[%0d]: done %b err %0d en %b, want 1 1 000", i, op_done,
                 op_err, {en_erase_page, en_write_page, en_read});
        miscompares++;
      end
      tick(1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [1:0] err;
    issue_cmd(2'd2, {12'd4095, 6'd63}, 16'd2);
    for (int i = 0; i < 2; i++) begin
      wait_en(1, 20, ok);
      if (i == 1) begin
        vectors++;
        if (!ok || row_addr !== '0) begin
          $display("FAIL wrap_row: en %b row %0h, want 1 0", ok, row_addr);
          miscompares++;
        end
      end
      end_write_page = 1'b1;
      @(negedge clk);
      end_write_page = 1'b0;
    end
    wait_done(30, ok, err);
    vectors++;
    if (!ok || err !== 2'd0) begin
      $display("FAIL wrap_done: done %b err %0d, want 1 0", ok, err);
      miscompares++;
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dones;
    issue_cmd(2'd2, {12'd1, 6'd1}, 16'd2);
    wait_en(1, 20, ok);
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (!ok || en_write_page !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL rstmid_drop: en seen %b en %b ready %b, want 1 0 1", ok, en_write_page,
               cmd_ready);
      miscompares++;
    end
    dones = 0;
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (op_done || en_write_page) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      $display("FAIL rstmid_quiet: %0d cycles with op_done/en after reset, want 0", dones);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_row = '0;
    cmd_page_cnt = '0;
    end_erase_page = 1'b0;
    end_write_page = 1'b0;
    end_read = 1'b0;
    nandflash_busy_Noresponse = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_erase();
    test_read_hold();
    test_timeout();
    test_busy();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
